// File: rtl/switch_debouncer.sv
// Per-switch debouncer: polarity normalise, 2-flop sync, 4-state debounce FSM.
// Optional long-press strobe is built only when LONG_PRESS_EN is defined.
module switch_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int SW_ACTIVE_LOW     = 0,
  parameter int CW                = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_stb,
  output logic rel_stb,
  output logic long_stb
);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

  localparam logic          INV       = (SW_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sync;
  logic          s;
  logic          level_n, press_n, rel_n, long_n;
  logic          long_done, long_done_n;

  assign s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      state     <= RELEASED;
      cnt       <= '0;
      level     <= 1'b0;
      press_stb <= 1'b0;
      rel_stb   <= 1'b0;
      long_stb  <= 1'b0;
      long_done <= 1'b0;
    end else begin
      sync      <= {sync[0], raw ^ INV};
      state     <= state_n;
      cnt       <= cnt_n;
      level     <= level_n;
      press_stb <= press_n;
      rel_stb   <= rel_n;
      long_stb  <= long_n;
      long_done <= long_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    level_n     = level;
    press_n     = 1'b0;
    rel_n       = 1'b0;
    long_n      = 1'b0;
    long_done_n = long_done;
    case (state)
      RELEASED: begin
        if (s) begin
          state_n = PRESS_PEND;
          cnt_n   = '0;
        end
      end
      PRESS_PEND: begin
        if (!s) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_PEND;
          cnt_n   = '0;
        end else begin
`ifdef LONG_PRESS_EN
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
          // long_done keeps a bounced-back press from firing a second time
          if (cnt == LONG_LAST && !long_done) begin
            long_n      = 1'b1;
            long_done_n = 1'b1;
          end
`endif
        end
      end
      RELEASE_PEND: begin
        if (s) begin
          state_n = PRESSED;
        end else if (cnt == DEB_LAST) begin
          state_n     = RELEASED;
          cnt_n       = '0;
          level_n     = 1'b0;
          rel_n       = 1'b1;
          long_done_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RELEASED;
    endcase
  end
endmodule

module switch_debouncer #(
  parameter int NUM_SW            = 2,
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int SW_ACTIVE_LOW     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_press,
  output logic [NUM_SW-1:0] sw_release,
  output logic [NUM_SW-1:0] sw_long
);
  localparam int MAXC = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int CW   = $clog2(MAXC);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    switch_debouncer_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .SW_ACTIVE_LOW    (SW_ACTIVE_LOW),
      .CW               (CW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (sw_raw[i]),
      .level    (sw_level[i]),
      .press_stb(sw_press[i]),
      .rel_stb  (sw_release[i]),
      .long_stb (sw_long[i])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (D=4, L=20, 2 channels); strobes are
// checked against a queue of expected (cycle, press, release, long) events.
module tb_switch_debouncer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw_raw, sw_level, sw_press, sw_release, sw_long;

  switch_debouncer #(.NUM_SW(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .SW_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_level(sw_level),
    .sw_press(sw_press), .sw_release(sw_release), .sw_long(sw_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  p, r, l;
  } ev_t;

  ev_t         q[$];
  int unsigned cyc = 0;
  int          total = 0, bad = 0;
  int unsigned c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int unsigned at, input logic [1:0] p, r, l);
    ev_t e;
    e.cyc = at; e.p = p; e.r = r; e.l = l;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (|{sw_press, sw_release, sw_long}) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: cycle %0d p=%b r=%b l=%b, none expected",
                 cyc, sw_press, sw_release, sw_long);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.p !== sw_press || e.r !== sw_release || e.l !== sw_long) begin
          bad++;
          $display("FAIL strobe_event: got cycle %0d p=%b r=%b l=%b expected cycle %0d p=%b r=%b l=%b",
                   cyc, sw_press, sw_release, sw_long, e.cyc, e.p, e.r, e.l);
        end
      end
    end
  end

  initial begin
    // 1: reset with both held, both accepted together 7 edges after reset release
    rst_n = 1'b0; sw_raw = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sw_level, sw_press, sw_release, sw_long}, 8'h00);
    rst_n = 1'b1; c = cyc;
    expect_ev(c + 7, 2'b11, 2'b00, 2'b00);
    repeat (9) @(negedge clk);
    chk("t1_level_high", {6'd0, sw_level}, 8'h03);
    sw_raw = 2'b00; c = cyc;
    expect_ev(c + 7, 2'b00, 2'b11, 2'b00);
    repeat (10) @(negedge clk);
    chk("t1_level_low", {6'd0, sw_level}, 8'h00);

    // 2: 3-cycle pulse is a glitch
    sw_raw = 2'b01;
    repeat (3) @(negedge clk);
    chk("t2_level_during", {6'd0, sw_level}, 8'h00);
    sw_raw = 2'b00;
    repeat (10) @(negedge clk);
    chk("t2_level_after", {6'd0, sw_level}, 8'h00);

    // 3: 20-cycle hold
    sw_raw = 2'b01; c = cyc;
    expect_ev(c + 7, 2'b01, 2'b00, 2'b00);
    repeat (12) @(negedge clk);
    chk("t3_level_mid", {6'd0, sw_level}, 8'h01);
    repeat (8) @(negedge clk);
    sw_raw = 2'b00;
    expect_ev(c + 27, 2'b00, 2'b01, 2'b00);
    repeat (10) @(negedge clk);
    chk("t3_level_end", {6'd0, sw_level}, 8'h00);

    // 4: 2-cycle low glitch while pressed
    sw_raw = 2'b01; c = cyc;
    expect_ev(c + 7, 2'b01, 2'b00, 2'b00);
    repeat (12) @(negedge clk);
    sw_raw = 2'b00;
    repeat (2) @(negedge clk);
    sw_raw = 2'b01;
    repeat (4) @(negedge clk);
    chk("t4_level_after_glitch", {6'd0, sw_level}, 8'h01);
    repeat (2) @(negedge clk);
    sw_raw = 2'b00;
    expect_ev(c + 27, 2'b00, 2'b01, 2'b00);
    repeat (10) @(negedge clk);
    chk("t4_level_end", {6'd0, sw_level}, 8'h00);

    // 5: 40-cycle hold on channel 1
    sw_raw = 2'b10; c = cyc;
    expect_ev(c + 7, 2'b10, 2'b00, 2'b00);
`ifdef LONG_PRESS_EN
    expect_ev(c + 27, 2'b00, 2'b00, 2'b10);
`endif
    repeat (40) @(negedge clk);
    chk("t5_level_held", {6'd0, sw_level}, 8'h02);
    sw_raw = 2'b00;
    expect_ev(c + 47, 2'b00, 2'b10, 2'b00);
    repeat (10) @(negedge clk);
    chk("t5_level_end", {6'd0, sw_level}, 8'h00);

    // 6: reset during PRESS_PEND, then re-debounce of the held switch
    sw_raw = 2'b01;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", {sw_level, sw_press, sw_release, sw_long}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; c = cyc;
    expect_ev(c + 7, 2'b01, 2'b00, 2'b00);
    repeat (10) @(negedge clk);
    chk("t6_level_high", {6'd0, sw_level}, 8'h01);
    sw_raw = 2'b00; c = cyc;
    expect_ev(c + 7, 2'b00, 2'b01, 2'b00);
    repeat (10) @(negedge clk);
    chk("t6_level_low", {6'd0, sw_level}, 8'h00);

    chk("missing_events", 8'(q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
